pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Reset and lock supervisor that sits directly downstream of the iCE40 PLL wrapper and runs in the PLL output clock domain. It synchronizes the PLL `locked` flag and waits for it to stay high for a programmable stable interval. It then holds the fast-domain reset for a further programmable interval and only then releases a synchronous-deassert reset to the fast logic. Loss of lock re-asserts that reset and is counted for firmware diagnostics.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before reset hold begins; range 1..2^CNT_W.
- `RESET_HOLD_CYCLES`, default 16: cycles reset stays asserted after lock is deemed stable; range 1..2^CNT_W.
- `CNT_W`, default 16: width of the shared interval counter.
- `clock_in`, in, 1: PLL output clock, 220 MHz; the only clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `locked`, in, 1: PLL lock flag; asynchronous to `clock_in`.
- `lock_loss_clr`, in, 1: single-cycle pulse that clears `lock_loss_count`.
- `rst_out_n`, out, 1: active-low reset for fast-domain logic.
- `ready`, out, 1: high when the domain is running.
- `state`, out, 2: current FSM state.
- `lock_loss_count`, out, 8: number of lock losses seen from RUN; saturates.

## Operation
- **Reset and internal reset**
  - One clock, `clock_in`. `reset_n` is asynchronous and active-low.
  - `reset_n` low asynchronously clears a 2-flop reset synchronizer, giving internal `rst_int_n` = 0.
  - `rst_int_n` deasserts on the 2nd `clock_in` edge after `reset_n` rises.
  - `rst_int_n` asynchronously resets every other flop.
- **Reset values**
  - `state` = WAIT_LOCK (00).
  - `rst_out_n` = 0, `ready` = 0.
  - `lock_loss_count` = 0.
  - Interval counter = 0.
  - Both `locked` synchronizer flops = 0.
- **Lock synchronization:** `locked` passes through a 2-flop synchronizer to give `lock_s`. The FSM uses only `lock_s`.
- **WAIT_LOCK (00)**
  - Counter held at 0.
  - `lock_s` = 1 → STABILIZE.
- **STABILIZE (01)**
  - `lock_s` = 0 → WAIT_LOCK, counter cleared. This is a glitch and is not counted.
  - Otherwise, counter = LOCK_STABLE_CYCLES−1 → HOLD_RST with counter cleared; else the counter increments.
- **HOLD_RST (10)**
  - `lock_s` = 0 → WAIT_LOCK. Not counted.
  - Otherwise, counter = RESET_HOLD_CYCLES−1 → RUN with counter cleared; else the counter increments.
- **RUN (11)**
  - `lock_s` = 0 → WAIT_LOCK, and `lock_loss_count` increments.
- **Output decode**
  - `rst_out_n` = `ready` = (state == RUN).
  - Outputs are decoded from the state register only. There is no combinational path from `locked`.
- **lock_loss_count**
  - 8-bit counter, saturates at 255.
  - `lock_loss_clr` alone sets it to 0.
  - `lock_loss_clr` in the same cycle as a counted loss sets it to 1.
- **Counter:** shared, CNT_W bits. It never wraps, because the terminal compare precedes the increment.

## Timing
- **Entering STABILIZE:** number `clock_in` edges from the first edge that samples `locked` = 1 with `rst_int_n` = 1 as edge 1. `lock_s` = 1 after edge 2, and state = STABILIZE after edge 3.
- **Time in STABILIZE and HOLD_RST:** exactly LOCK_STABLE_CYCLES cycles in STABILIZE, then exactly RESET_HOLD_CYCLES cycles in HOLD_RST.
- **Release:** RUN, `rst_out_n` = 1 and `ready` = 1 after edge 3 + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES.
- **Lock loss:** number the first edge that samples `locked` = 0 as edge 1. State = WAIT_LOCK, with `rst_out_n` = 0 and `ready` = 0, after edge 2 + 1 = edge 3. `lock_loss_count` updates on that same edge.
- **Glitch filtering:** a `locked` pulse shorter than one cycle may be missed; this is acceptable. A `locked` low pulse of one or more cycles during STABILIZE or HOLD_RST restarts the full sequence.
- **Reset mid-operation:** `reset_n` low in any state drives `rst_out_n` low asynchronously, within the same cycle. It also clears `lock_loss_count`.
- **Power-up with `locked` already high:** `reset_n` rises before edge 1. `rst_int_n` = 1 after edge 2, `lock_s` = 1 after edge 4, STABILIZE after edge 5, and RUN after edge 5 + L + H.

## Test plan
All scenarios use LOCK_STABLE_CYCLES = 8 and RESET_HOLD_CYCLES = 4.

- **Power-up with lock:** `locked` tied high, `reset_n` released before edge 1 → `state` 00 through edge 4, 01 after edge 5, 10 after edge 13, 11 after edge 17. `rst_out_n` and `ready` rise after edge 17 and never before.
- **Lock glitch during STABILIZE:** `locked` driven low for 2 cycles while in STABILIZE → return to WAIT_LOCK, `lock_loss_count` stays 0. After `locked` returns high, the full 8 + 4 cycle sequence repeats from the start.
- **Lock loss in RUN:** `locked` falls (first sampling edge = edge 1) → `rst_out_n` = 0 and `state` = 00 after edge 3, `lock_loss_count` = 1. On relock, RUN is reached 15 edges after the first edge that samples `locked` = 1.
- **Saturation and clear:** 300 lock-loss cycles → `lock_loss_count` = 255. A `lock_loss_clr` pulse → 0. `lock_loss_clr` on the same edge as a counted loss → 1.
- **Async reset in RUN:** `reset_n` pulsed low mid-cycle → `rst_out_n` and `ready` go low before the next edge, `state` = 00, `lock_loss_count` = 0. After release, RUN is reached after edge 17 again.
- **Minimum parameters:** LOCK_STABLE_CYCLES = 1, RESET_HOLD_CYCLES = 1 → exactly 1 cycle each in STABILIZE and HOLD_RST, with no counter wrap.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Lock supervisor for the PLL output clock domain: filters the PLL lock flag,
// then sequences a synchronous-deassert reset for the fast logic.
//
// state     | meaning
// WAIT_LOCK | waiting for synchronized lock, counter held at 0
// STABILIZE | lock seen, counting LOCK_STABLE_CYCLES of uninterrupted lock
// HOLD_RST  | lock stable, holding reset for RESET_HOLD_CYCLES
// RUN       | fast domain released; loss of lock is counted
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CNT_W              = 16
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       lock_loss_clr,
  output logic       rst_out_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    STABILIZE = 2'b01,
    HOLD_RST  = 2'b10,
    RUN       = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic [1:0]       lock_sync;
  logic             lock_s;
  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             run_q;
  logic             loss;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clock_in or negedge rst_int_n) begin
    if (!rst_int_n) lock_sync <= 2'b00;
    else            lock_sync <= {lock_sync[0], locked};
  end

  assign lock_s = lock_sync[1];
  assign loss   = (st == RUN) && !lock_s;

  // Terminal compare comes before the increment, so the counter never wraps.
  always_ff @(posedge clock_in or negedge rst_int_n) begin
    if (!rst_int_n) begin
      st    <= WAIT_LOCK;
      cnt   <= '0;
      run_q <= 1'b0;
    end else begin
      case (st)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lock_s) st <= STABILIZE;
        end
        STABILIZE: begin
          if (!lock_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STABLE_TC) begin
            st  <= HOLD_RST;
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD_RST: begin
          if (!lock_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == HOLD_TC) begin
            st    <= RUN;
            cnt   <= '0;
            run_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= '0;
          if (!lock_s) begin
            st    <= WAIT_LOCK;
            run_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // A clear coinciding with a counted loss keeps that loss.
  always_ff @(posedge clock_in or negedge rst_int_n) begin
    if (!rst_int_n) begin
      lock_loss_count <= 8'd0;
    end else if (lock_loss_clr) begin
      lock_loss_count <= loss ? 8'd1 : 8'd0;
    end else if (loss && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  assign state     = st;
  assign rst_out_n = run_q;
  assign ready     = run_q;

endmodule
